// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the program-counter step controller.
//   state_t     : controller FSM states (STEP exists only with PC_SINGLE_STEP_EN)
//   PCSEL_*     : pc_sel encodings understood by the PC register
//   ADDR_W      : program counter width
// Optional feature macro: PC_SINGLE_STEP_EN
package pc_ctrl_pkg;

    localparam int unsigned ADDR_W = 8;

    localparam logic [1:0] PCSEL_HOLD   = 2'b00;
    localparam logic [1:0] PCSEL_INC    = 2'b01;
    localparam logic [1:0] PCSEL_TARGET = 2'b10;
    localparam logic [1:0] PCSEL_ZERO   = 2'b11;

`ifdef PC_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_IN,
        ST_HALT,
        ST_STEP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_IN,
        ST_HALT
    } state_t;
`endif

endpackage

// File: rtl/pc_step_controller_button_debounce.sv
// button_debounce: turns a raw active-low asynchronous pushbutton into a
// single-cycle press pulse.
//   clk, reset : system clock, synchronous active-high reset
//   button_n   : raw pushbutton, active-low, asynchronous
//   press      : one-cycle pulse once the button has been seen low for
//                DEB_CYCLES consecutive synchronised cycles
// Parameters: DEB_CYCLES (1..255), DEB_W (counter width).
// Latency from a stable low on button_n to press is DEB_CYCLES+2 cycles.
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DEB_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic button_n,
    output logic press
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES);
    localparam logic [DEB_W-1:0] CNT_PRE = DEB_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] cnt;

    // Counter saturates at CNT_MAX so a held button yields one pulse; the
    // pulse is registered on the increment that reaches CNT_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt   <= cnt + 1'b1;
                press <= (cnt == CNT_PRE);
            end
        end
    end

endmodule

// File: rtl/pc_step_controller.sv
// pc_step_controller: control FSM sequencing the program counter.
// Each cycle chooses hold / increment / load target / clear for the PC and
// handles halt, wait-for-user-input and restart from the debounced button.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   op_halt         : decoded HALT at current PC
//   op_input        : decoded IN (waits for user confirmation)
//   op_jump         : decoded J/JAL
//   op_branch       : decoded conditional branch
//   alu_cond        : ALU branch condition
//   step_mode       : single-step enable (only with PC_SINGLE_STEP_EN)
//   button_n        : raw pushbutton, active-low, asynchronous
//   pc_we, pc_sel   : PC register write enable / source select
//   link_we         : write PC+1 to link register (jump)
//   in_ack          : one-cycle pulse, user input accepted
//   retire          : one-cycle pulse per completed instruction
//   halted, waiting : status while in HALT / WAIT_IN
//   press           : debounced press pulse (debug)
// Optional feature macro: PC_SINGLE_STEP_EN
module pc_step_controller
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DEB_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_halt,
    input  logic       op_input,
    input  logic       op_jump,
    input  logic       op_branch,
    input  logic       alu_cond,
`ifdef PC_SINGLE_STEP_EN
    input  logic       step_mode,
`endif
    input  logic       button_n,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       link_we,
    output logic       in_ack,
    output logic       retire,
    output logic       halted,
    output logic       waiting,
    output logic       press
);

    state_t state;
    state_t state_next;

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .button_n (button_n),
        .press    (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        pc_sel     = PCSEL_HOLD;
        link_we    = 1'b0;
        in_ack     = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        waiting    = 1'b0;

        // While reset is held the outputs stay quiet with pc_sel pointing at
        // ZERO, rather than showing the BOOT write early.
        if (reset) begin
            pc_sel     = PCSEL_ZERO;
            state_next = ST_BOOT;
        end else begin
            case (state)
                ST_BOOT: begin
                    pc_we      = 1'b1;
                    pc_sel     = PCSEL_ZERO;
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (op_halt) begin
                        retire     = 1'b1;
                        state_next = ST_HALT;
                    end else if (op_input) begin
                        state_next = ST_WAIT_IN;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        if (op_jump) begin
                            pc_sel  = PCSEL_TARGET;
                            link_we = 1'b1;
                        end else if (op_branch && alu_cond) begin
                            pc_sel = PCSEL_TARGET;
                        end else begin
                            pc_sel = PCSEL_INC;
                        end
`ifdef PC_SINGLE_STEP_EN
                        if (step_mode) begin
                            state_next = ST_STEP;
                        end
`endif
                    end
                end
                ST_WAIT_IN: begin
                    waiting = 1'b1;
                    if (press) begin
                        in_ack     = 1'b1;
                        pc_we      = 1'b1;
                        pc_sel     = PCSEL_INC;
                        retire     = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (press) begin
                        state_next = ST_BOOT;
                    end
                end
`ifdef PC_SINGLE_STEP_EN
                ST_STEP: begin
                    if (press) begin
                        state_next = ST_RUN;
                    end
                end
`endif
                default: begin
                    state_next = ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_step_controller.sv
// Self-checking bench for pc_step_controller (default build, DEB_CYCLES=4).
// Deterministic table of vectors, hand sequences for long presses and reset
// during debounce, then randomized stimulus checked against a reference model.
module tb_pc_step_controller;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_halt = 1'b0;
    logic       op_input = 1'b0;
    logic       op_jump = 1'b0;
    logic       op_branch = 1'b0;
    logic       alu_cond = 1'b0;
    logic       button_n = 1'b1;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       link_we;
    logic       in_ack;
    logic       retire;
    logic       halted;
    logic       waiting;
    logic       press;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pc_step_controller #(
        .DEB_CYCLES (DEB),
        .DEB_W      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_halt   (op_halt),
        .op_input  (op_input),
        .op_jump   (op_jump),
        .op_branch (op_branch),
        .alu_cond  (alu_cond),
        .button_n  (button_n),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .link_we   (link_we),
        .in_ack    (in_ack),
        .retire    (retire),
        .halted    (halted),
        .waiting   (waiting),
        .press     (press)
    );

    // Output bundle: {pc_we, pc_sel[1:0], link_we, in_ack, retire, halted, waiting, press}
    logic [8:0] outv;
    assign outv = {pc_we, pc_sel, link_we, in_ack, retire, halted, waiting, press};

    // Input bundle: {reset, op_halt, op_input, op_jump, op_branch, alu_cond, button_n}
    localparam logic [6:0] I_IDLE = 7'b0000001;
    localparam logic [6:0] I_RST  = 7'b1000001;
    localparam logic [6:0] I_RSTL = 7'b1000000;
    localparam logic [6:0] I_JMP  = 7'b0001001;
    localparam logic [6:0] I_BRNT = 7'b0000101;
    localparam logic [6:0] I_BRT  = 7'b0000111;
    localparam logic [6:0] I_INP  = 7'b0010001;
    localparam logic [6:0] I_LOW  = 7'b0000000;
    localparam logic [6:0] I_HJ   = 7'b0101001;

    localparam logic [8:0] O_RST   = 9'b0_11_000000;
    localparam logic [8:0] O_BOOT  = 9'b1_11_000000;
    localparam logic [8:0] O_INC   = 9'b1_01_001000;
    localparam logic [8:0] O_JMP   = 9'b1_10_101000;
    localparam logic [8:0] O_BRT   = 9'b1_10_001000;
    localparam logic [8:0] O_NONE  = 9'b0_00_000000;
    localparam logic [8:0] O_WAIT  = 9'b0_00_000010;
    localparam logic [8:0] O_ACK   = 9'b1_01_011011;
    localparam logic [8:0] O_HLTE  = 9'b0_00_001000;
    localparam logic [8:0] O_HALT  = 9'b0_00_000100;
    localparam logic [8:0] O_HALTP = 9'b0_00_000101;

    typedef struct {
        logic [6:0] in;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    typedef enum int {M_BOOT, M_RUN, M_WAIT, M_HALT} mode_t;
    mode_t mode = M_BOOT;
    logic  press_m = 1'b0;
    logic  hist[$];   // button_n value seen at each clock edge

    // Press fires when the run of lows in the button history, as seen two
    // synchroniser edges ago, has reached exactly DEB.
    function automatic logic press_after(input logic h[$]);
        int n = 0;
        for (int idx = h.size() - 3; idx >= 0; idx--) begin
            if (h[idx] != 1'b0 || n > DEB) break;
            n++;
        end
        return (n == DEB);
    endfunction

    function automatic logic [8:0] model_out(input logic [6:0] in);
        logic [8:0] r;
        r = O_NONE;
        if (in[6]) begin
            r = O_RST;
        end else begin
            case (mode)
                M_BOOT: r = O_BOOT;
                M_RUN: begin
                    if (in[5])                r = O_HLTE;
                    else if (in[4])           r = O_NONE;
                    else if (in[3])           r = O_JMP;
                    else if (in[2] && in[1])  r = O_BRT;
                    else                      r = O_INC;
                end
                M_WAIT: r = press_m ? O_ACK : O_WAIT;
                M_HALT: r = O_HALT;
                default: r = O_NONE;
            endcase
            r[0] = press_m;
        end
        return r;
    endfunction

    task automatic model_edge(input logic [6:0] in);
        if (in[6]) begin
            mode    = M_BOOT;
            press_m = 1'b0;
            hist.delete();
            hist.push_back(1'b1);
            hist.push_back(1'b1);
        end else begin
            case (mode)
                M_BOOT: mode = M_RUN;
                M_RUN: begin
                    if (in[5])      mode = M_HALT;
                    else if (in[4]) mode = M_WAIT;
                end
                M_WAIT: if (press_m) mode = M_RUN;
                M_HALT: if (press_m) mode = M_BOOT;
                default: mode = M_BOOT;
            endcase
            hist.push_back(in[0]);
            if (hist.size() > 16) void'(hist.pop_front());
            press_m = press_after(hist);
        end
    endtask

    // ---------------- driving and checking ----------------
    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got {we,sel,link,ack,ret,halt,wait,press}=%b required %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // One clock cycle: drive, settle, optionally compare, advance the model.
    task automatic cycle(input logic [6:0] in, input bit use_tbl, input logic [8:0] texp,
                         input string name, output logic [8:0] got);
        @(negedge clk);
        {reset, op_halt, op_input, op_jump, op_branch, alu_cond, button_n} = in;
        #1;
        got = outv;
        if (use_tbl) check(name, outv, texp);
        else         check(name, outv, model_out(in));
        model_edge(in);
    endtask

    task automatic add(input logic [6:0] in, input logic [8:0] exp, input int rep);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        for (int k = 0; k < rep; k++) tbl.push_back(v);
    endtask

    initial begin
        logic [8:0] got;
        logic [6:0] rin;
        logic       bn_r;
        int         presses;
        int         acks;
        int         first_press;

        hist.push_back(1'b1);
        hist.push_back(1'b1);

        // Reset, boot, run, jump/branch, input wait with a 6-cycle press,
        // halt+jump together, glitch in HALT, proper press restarts at 0.
        add(I_RST,  O_RST,   1);
        add(I_IDLE, O_BOOT,  1);
        add(I_IDLE, O_INC,   2);
        add(I_JMP,  O_JMP,   1);
        add(I_BRNT, O_INC,   1);
        add(I_BRT,  O_BRT,   1);
        add(I_INP,  O_NONE,  1);
        add(I_IDLE, O_WAIT,  2);
        add(I_LOW,  O_WAIT,  6);
        add(I_IDLE, O_ACK,   1);
        add(I_IDLE, O_INC,   1);
        add(I_HJ,   O_HLTE,  1);
        add(I_IDLE, O_HALT,  1);
        add(I_LOW,  O_HALT,  2);
        add(I_IDLE, O_HALT,  4);
        add(I_LOW,  O_HALT,  6);
        add(I_IDLE, O_HALTP, 1);
        add(I_IDLE, O_BOOT,  1);
        add(I_IDLE, O_INC,   1);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("vec%0d", i), got);
        end

        // Wait for input for 20 cycles, then hold the button low for 50
        // cycles: only one press and one acknowledge.
        cycle(I_INP, 1'b0, '0, "seqA_inp", got);
        for (int i = 0; i < 20; i++) cycle(I_IDLE, 1'b0, '0, "seqA_wait", got);
        presses = 0;
        acks    = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(I_LOW, 1'b0, '0, "seqA_hold", got);
            if (got[0]) presses++;
            if (got[4]) acks++;
        end
        check_int("seqA_press_count", presses, 1);
        check_int("seqA_ack_count", acks, 1);
        for (int i = 0; i < 3; i++) cycle(I_IDLE, 1'b0, '0, "seqA_after", got);

        // Reset while waiting with the button half-debounced; the button is
        // kept low through and after reset.
        cycle(I_INP, 1'b0, '0, "seqB_inp", got);
        cycle(I_IDLE, 1'b0, '0, "seqB_wait", got);
        for (int i = 0; i < 3; i++) cycle(I_LOW, 1'b0, '0, "seqB_half", got);
        cycle(I_RSTL, 1'b0, '0, "seqB_reset", got);
        acks        = 0;
        first_press = -1;
        for (int t = 0; t < 12; t++) begin
            cycle(I_LOW, 1'b0, '0, "seqB_post", got);
            if (t == 0) check("seqB_boot", got, O_BOOT);
            if (got[4]) acks++;
            if (got[0] && first_press < 0) first_press = t;
        end
        check_int("seqB_no_ack", acks, 0);
        check_int("seqB_press_cycle", first_press, DEB + 2);

        // Randomized stimulus against the model.
        bn_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) bn_r = ~bn_r;
            rin[6] = ($urandom_range(0, 149) == 0);
            rin[5] = ($urandom_range(0, 19) == 0);
            rin[4] = ($urandom_range(0, 9) == 0);
            rin[3] = ($urandom_range(0, 5) == 0);
            rin[2] = ($urandom_range(0, 3) == 0);
            rin[1] = 1'($urandom_range(0, 1));
            rin[0] = bn_r;
            cycle(rin, 1'b0, '0, "rand", got);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
